// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and sizing for the RS-232 receive buffer.
// Capture FSM encoding, character width and default FIFO depth.
package rs232_pkg;

    localparam int CHAR_W    = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } rxState_t;

endpackage

// File: rtl/rs232_rx_buf_if.sv
// rs232_rx_buf_if: receiver-side and consumer-side signals of the buffer.
// master drives characters/pops, slave is the buffer itself.
interface rs232_rx_buf_if
    import rs232_pkg::*;
#(
    parameter int AW = DEF_AW
);

    logic [CHAR_W-1:0] rData;
    logic              ready;
    logic              readSR;
    logic [CHAR_W-1:0] outData;
    logic              outValid;
    logic              outRead;
    logic [AW:0]       count;
    logic              overrun;
    logic              clrOverrun;

    modport master (
        output rData, ready, outRead, clrOverrun,
        input  readSR, outData, outValid, count, overrun
    );

    modport slave (
        input  rData, ready, outRead, clrOverrun,
        output readSR, outData, outValid, count, overrun
    );

endinterface

// File: rtl/rs232_fifo.sv
// rs232_fifo: first-word-fall-through character FIFO.
// Sync write, async read from unreset LUT storage.
module rs232_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic              Ph0,
    input  logic              Reset,
    input  logic              push,
    input  logic [CHAR_W-1:0] wData,
    input  logic              pop,
    output logic [CHAR_W-1:0] rdData,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    // a full FIFO still accepts a write when the head leaves this cycle
    assign doPush = push & (~full | doPop);
    assign rdData = mem[rdPtr];

    // storage write, deliberately without reset
    always_ff @(posedge Ph0) begin
        if (doPush) begin
            mem[wrPtr] <= wData;
        end
    end

    // pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge Ph0 or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rs232_rx_buf.sv
// rs232_rx_buf: captures UART characters into a FIFO.
// Pulses readSR once per character and flags dropped characters.
module rs232_rx_buf
    import rs232_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input logic            Ph0,
    input logic            Reset,
    rs232_rx_buf_if.slave  bus
);

    rxState_t state;
    rxState_t nextState;
    logic     capture;
    logic     readSRq;
    logic     overrunQ;
    logic     full;
    logic     empty;
    logic     dropped;

    rs232_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) fifo (
        .Ph0    (Ph0),
        .Reset  (Reset),
        .push   (capture),
        .wData  (bus.rData),
        .pop    (bus.outRead),
        .rdData (bus.outData),
        .count  (bus.count),
        .full   (full),
        .empty  (empty)
    );

    // a full FIFO with no pop loses the captured character
    assign dropped      = capture & full & ~bus.outRead;
    assign bus.outValid = ~empty;
    assign bus.readSR   = readSRq;
    assign bus.overrun  = overrunQ;

    // capture state and registered readSR pulse
    always_ff @(posedge Ph0 or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            readSRq <= 1'b0;
        end else begin
            state   <= nextState;
            readSRq <= capture;
        end
    end

    // SETTLE swallows the stale ready left over from the acknowledge
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ready) begin
                    capture   = 1'b1;
                    nextState = ACK;
                end
            end
            ACK:     nextState = SETTLE;
            SETTLE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // sticky overrun; a new drop beats a simultaneous clear
    always_ff @(posedge Ph0 or posedge Reset) begin
        if (Reset) begin
            overrunQ <= 1'b0;
        end else if (dropped) begin
            overrunQ <= 1'b1;
        end else if (bus.clrOverrun) begin
            overrunQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs232_rx_buf.sv
// tb_rs232_rx_buf: scenario tasks plus randomized traffic
// checked against a queue-based model of the receive buffer.
module tb_rs232_rx_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic Ph0;
    logic Reset;

    rs232_rx_buf_if #(.AW(AW)) bus ();

    rs232_rx_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .Ph0   (Ph0),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Ph0 = 1'b0;
    always #5 Ph0 = ~Ph0;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] q[$];
    bit  expOv;
    bit  expRsr;
    int  cool;
    int  pulses;
    int  expPulses;

    // one clock: apply inputs, advance the model, observe at negedge
    task automatic step(input logic rdy, input logic [7:0] d,
                        input logic rd, input logic clr);
        bit cap;
        bit drop;
        bus.ready      = rdy;
        bus.rData      = d;
        bus.outRead    = rd;
        bus.clrOverrun = clr;
        cap  = rdy && (cool == 0);
        drop = 0;
        if (rd && q.size() > 0) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) q.push_back(d);
            else drop = 1;
        end
        if (drop) expOv = 1;
        else if (clr) expOv = 0;
        expRsr = cap;
        if (cap) expPulses++;
        cool = cap ? 2 : (cool > 0 ? cool - 1 : 0);
        @(posedge Ph0);
        @(negedge Ph0);
        if (bus.readSR === 1'b1) pulses++;
    endtask

    task automatic modelReset();
        q.delete();
        expOv  = 0;
        expRsr = 0;
        cool   = 0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        modelReset();
        @(negedge Ph0);
        Reset = 1'b0;
        pulses    = 0;
        expPulses = 0;
    endtask

    // receiver behaviour: ready drops once readSR has been seen
    task automatic sendChar(input logic [7:0] d, input logic rd);
        step(1'b1, d, rd, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        doReset();
        nChecks++; if (bus.count !== 5'd0) $display("FAIL reset_count got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.outValid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.outValid); else nPass++;
        nChecks++; if (bus.readSR !== 1'b0) $display("FAIL reset_readSR got %b want 0", bus.readSR); else nPass++;
        nChecks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.overrun); else nPass++;
    endtask

    task automatic test_single();
        doReset();
        step(1'b1, 8'h41, 1'b0, 1'b0);
        nChecks++; if (bus.readSR !== 1'b1) $display("FAIL single_readSR got %b want 1", bus.readSR); else nPass++;
        nChecks++; if (bus.outValid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.outValid); else nPass++;
        nChecks++; if (bus.outData !== 8'h41) $display("FAIL single_data got %h want 41", bus.outData); else nPass++;
        nChecks++; if (bus.count !== 5'd1) $display("FAIL single_count got %0d want 1", bus.count); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        nChecks++; if (bus.readSR !== 1'b0) $display("FAIL single_readSR_off got %b want 0", bus.readSR); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        nChecks++; if (pulses !== 1) $display("FAIL single_pulses got %0d want 1", pulses); else nPass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        nChecks++; if (bus.count !== 5'd0) $display("FAIL single_pop_count got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.outValid !== 1'b0) $display("FAIL single_pop_valid got %b want 0", bus.outValid); else nPass++;
    endtask

    task automatic test_stale();
        logic [7:0] d;
        doReset();
        d = 8'($urandom);
        for (int i = 0; i < 3; i++) step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        nChecks++; if (bus.count !== 5'd1) $display("FAIL stale_count got %0d want 1", bus.count); else nPass++;
        nChecks++; if (pulses !== 1) $display("FAIL stale_pulses got %0d want 1", pulses); else nPass++;
        nChecks++; if (bus.outData !== d) $display("FAIL stale_data got %h want %h", bus.outData, d); else nPass++;
    endtask

    task automatic test_fill_overrun();
        doReset();
        for (int i = 0; i < 17; i++) sendChar(8'(i), 1'b0);
        nChecks++; if (bus.count !== 5'd16) $display("FAIL fill_count got %0d want 16", bus.count); else nPass++;
        nChecks++; if (bus.overrun !== 1'b1) $display("FAIL fill_overrun got %b want 1", bus.overrun); else nPass++;
        nChecks++; if (pulses !== 17) $display("FAIL fill_pulses got %0d want 17", pulses); else nPass++;
        for (int i = 0; i < 16; i++) begin
            nChecks++; if (bus.outData !== 8'(i)) $display("FAIL fill_order[%0d] got %h want %h", i, bus.outData, 8'(i)); else nPass++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        nChecks++; if (bus.outValid !== 1'b0) $display("FAIL fill_drained got %b want 0", bus.outValid); else nPass++;
        nChecks++; if (bus.overrun !== 1'b1) $display("FAIL fill_sticky got %b want 1", bus.overrun); else nPass++;
    endtask

    task automatic test_full_pop();
        logic [7:0] last;
        doReset();
        for (int i = 0; i < 16; i++) sendChar(8'($urandom), 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        nChecks++; if (bus.count !== 5'd16) $display("FAIL fullpop_count got %0d want 16", bus.count); else nPass++;
        nChecks++; if (bus.overrun !== expOv) $display("FAIL fullpop_overrun got %b want %b", bus.overrun, expOv); else nPass++;
        nChecks++; if (bus.readSR !== 1'b1) $display("FAIL fullpop_readSR got %b want 1", bus.readSR); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        last = 8'h00;
        while (q.size() > 0) begin
            nChecks++; if (bus.outData !== q[0]) $display("FAIL fullpop_data got %h want %h", bus.outData, q[0]); else nPass++;
            last = bus.outData;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        nChecks++; if (last !== 8'hAA) $display("FAIL fullpop_last got %h want aa", last); else nPass++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        int maxCount;
        int bad;
        doReset();
        maxCount = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            step(1'b1, d, 1'b0, 1'b0);
            if (int'(bus.count) > maxCount) maxCount = int'(bus.count);
            if (bus.outData !== d) bad++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (int'(bus.count) > maxCount) maxCount = int'(bus.count);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        nChecks++; if (bad !== 0) $display("FAIL wrap_data got %0d bad want 0", bad); else nPass++;
        nChecks++; if (maxCount > 1) $display("FAIL wrap_maxcount got %0d want <=1", maxCount); else nPass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        nChecks++; if (bus.count !== 5'd0) $display("FAIL pop_empty_count got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.outValid !== 1'b0) $display("FAIL pop_empty_valid got %b want 0", bus.outValid); else nPass++;
        d = 8'($urandom);
        sendChar(d, 1'b0);
        nChecks++; if (bus.outData !== d) $display("FAIL pop_empty_next got %h want %h", bus.outData, d); else nPass++;
    endtask

    task automatic test_reset_ack();
        logic [7:0] d;
        doReset();
        sendChar(8'h5A, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        nChecks++; if (bus.readSR !== 1'b1) $display("FAIL rstack_pre got %b want 1", bus.readSR); else nPass++;
        Reset = 1'b1;
        #1;
        nChecks++; if (bus.readSR !== 1'b0) $display("FAIL rstack_readSR got %b want 0", bus.readSR); else nPass++;
        nChecks++; if (bus.count !== 5'd0) $display("FAIL rstack_count got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.outValid !== 1'b0) $display("FAIL rstack_valid got %b want 0", bus.outValid); else nPass++;
        modelReset();
        @(negedge Ph0);
        Reset = 1'b0;
        d = 8'($urandom);
        step(1'b1, d, 1'b0, 1'b0);
        nChecks++; if (bus.readSR !== 1'b1) $display("FAIL rstack_recap got %b want 1", bus.readSR); else nPass++;
        nChecks++; if (bus.count !== 5'd1) $display("FAIL rstack_recount got %0d want 1", bus.count); else nPass++;
        nChecks++; if (bus.outData !== d) $display("FAIL rstack_data got %h want %h", bus.outData, d); else nPass++;
    endtask

    task automatic test_clr_coincident();
        doReset();
        for (int i = 0; i < 17; i++) sendChar(8'($urandom), 1'b0);
        nChecks++; if (bus.overrun !== 1'b1) $display("FAIL clr_set got %b want 1", bus.overrun); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        nChecks++; if (bus.overrun !== 1'b0) $display("FAIL clr_clear got %b want 0", bus.overrun); else nPass++;
        step(1'b1, 8'h77, 1'b0, 1'b1);
        nChecks++; if (bus.overrun !== 1'b1) $display("FAIL clr_coincident got %b want 1", bus.overrun); else nPass++;
        nChecks++; if (bus.count !== 5'd16) $display("FAIL clr_count got %0d want 16", bus.count); else nPass++;
    endtask

    task automatic test_random();
        logic rdy;
        logic rd;
        logic clr;
        doReset();
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step(rdy, 8'($urandom), rd, clr);
            nChecks++; if (bus.count !== 5'(q.size())) $display("FAIL rnd_count@%0d got %0d want %0d", i, bus.count, q.size()); else nPass++;
            nChecks++; if (bus.outValid !== (q.size() != 0)) $display("FAIL rnd_valid@%0d got %b want %b", i, bus.outValid, q.size() != 0); else nPass++;
            nChecks++; if (bus.readSR !== expRsr) $display("FAIL rnd_readSR@%0d got %b want %b", i, bus.readSR, expRsr); else nPass++;
            nChecks++; if (bus.overrun !== expOv) $display("FAIL rnd_overrun@%0d got %b want %b", i, bus.overrun, expOv); else nPass++;
            if (q.size() != 0) begin
                nChecks++; if (bus.outData !== q[0]) $display("FAIL rnd_data@%0d got %h want %h", i, bus.outData, q[0]); else nPass++;
            end
        end
        nChecks++; if (pulses !== expPulses) $display("FAIL rnd_pulses got %0d want %0d", pulses, expPulses); else nPass++;
    endtask

    initial begin
        Reset          = 1'b0;
        bus.ready      = 1'b0;
        bus.rData      = 8'h00;
        bus.outRead    = 1'b0;
        bus.clrOverrun = 1'b0;
        modelReset();
        pulses    = 0;
        expPulses = 0;
        @(negedge Ph0);
        test_reset();
        test_single();
        test_stale();
        test_fill_overrun();
        test_full_pop();
        test_wrap();
        test_reset_ack();
        test_clr_coincident();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
